// File: rtl/peak_voltage_tracker_if.sv
// Stream/result bundle for peak_voltage_tracker: sweep control and tagged ADC
// samples in, published peak result and status out.
interface peak_voltage_tracker_if #(
  parameter int WIDTH = 8,
  parameter int POS_W = 8,
  parameter int CNT_W = 10
);
  logic             start;
  logic             stop;
  logic             sample_valid;
  logic [WIDTH-1:0] sample;
  logic [POS_W-1:0] pos;
  logic             gt;
  logic             busy;
  logic             done;
  logic             peak_valid;
  logic [WIDTH-1:0] max_val;
  logic [POS_W-1:0] max_pos;
  logic [CNT_W-1:0] sample_cnt;

  modport master (
    output start, stop, sample_valid, sample, pos,
    input  gt, busy, done, peak_valid, max_val, max_pos, sample_cnt
  );

  modport slave (
    input  start, stop, sample_valid, sample, pos,
    output gt, busy, done, peak_valid, max_val, max_pos, sample_cnt
  );
endinterface

// File: rtl/peak_voltage_tracker.sv
// Sweep-peak finder: running max of tagged ADC samples with hysteresis, published
// with a DONE pulse at sweep end. Define PEAK_TIE_LAST_EN to track a plateau's last position.
module peak_voltage_tracker #(
  parameter int WIDTH = 8,
  parameter int POS_W = 8,
  parameter int HYST  = 0,
  parameter int CNT_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  peak_voltage_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_PUBLISH
  } state_e;

  localparam logic [WIDTH:0] HYST_EXT = (WIDTH + 1)'(HYST);

  state_e           r_state;
  state_e           w_next;
  logic             w_busy;
  logic             w_done;

  logic [WIDTH-1:0] r_run_max;
  logic [POS_W-1:0] r_run_pos;
  logic             r_first;
  logic             r_gt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_max_val;
  logic [POS_W-1:0] r_max_pos;
  logic             r_peak_valid;

  logic [WIDTH:0]   w_thresh;
  logic             w_beats;
  logic             w_update;

  // One extra bit keeps run_max + HYST from wrapping, so a threshold above the
  // sample range simply never passes.
  assign w_thresh = {1'b0, r_run_max} + HYST_EXT;

`ifdef PEAK_TIE_LAST_EN
  assign w_beats  = {1'b0, bus.sample} >= w_thresh;
`else
  assign w_beats  = {1'b0, bus.sample} >  w_thresh;
`endif

  assign w_update = r_first || w_beats;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_SWEEP;
      end
      S_SWEEP: begin
        w_busy = 1'b1;
        if (!bus.start && bus.stop) w_next = S_PUBLISH;
      end
      S_PUBLISH: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_run_max    <= '0;
      r_run_pos    <= '0;
      r_first      <= 1'b0;
      r_gt         <= 1'b0;
      r_cnt        <= '0;
      r_max_val    <= '0;
      r_max_pos    <= '0;
      r_peak_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_gt <= 1'b0;
          if (bus.start) begin
            r_run_max <= '0;
            r_run_pos <= '0;
            r_cnt     <= '0;
            r_first   <= 1'b1;
          end
        end
        S_SWEEP: begin
          if (bus.start) begin
            // Restart wins over a same-cycle sample or STOP.
            r_run_max <= '0;
            r_run_pos <= '0;
            r_cnt     <= '0;
            r_first   <= 1'b1;
          end else if (bus.sample_valid) begin
            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
            if (w_update) begin
              r_run_max <= bus.sample;
              r_run_pos <= bus.pos;
              r_first   <= 1'b0;
              r_gt      <= 1'b1;
            end else begin
              r_gt      <= 1'b0;
            end
          end
        end
        S_PUBLISH: begin
          r_max_val    <= r_run_max;
          r_max_pos    <= r_run_pos;
          r_peak_valid <= !r_first;
        end
        default: ;
      endcase
    end
  end

  assign bus.gt         = r_gt;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.peak_valid = r_peak_valid;
  assign bus.max_val    = r_max_val;
  assign bus.max_pos    = r_max_pos;
  assign bus.sample_cnt = r_cnt;

endmodule

// File: tb/tb_peak_voltage_tracker.sv
// Bench for peak_voltage_tracker: three instances (HYST=0, HYST=5, CNT_W=3) share
// one stimulus stream and are compared every cycle against a sweep-level model.
module tb_peak_voltage_tracker;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       t_start = 1'b0;
  logic       t_stop  = 1'b0;
  logic       t_valid = 1'b0;
  logic [7:0] t_sample = '0;
  logic [7:0] t_pos    = '0;

  peak_voltage_tracker_if #(.WIDTH(8), .POS_W(8), .CNT_W(10)) if0 ();
  peak_voltage_tracker_if #(.WIDTH(8), .POS_W(8), .CNT_W(10)) if5 ();
  peak_voltage_tracker_if #(.WIDTH(8), .POS_W(8), .CNT_W(3))  if3 ();

  assign if0.start = t_start;  assign if0.stop = t_stop;  assign if0.sample_valid = t_valid;
  assign if0.sample = t_sample; assign if0.pos = t_pos;
  assign if5.start = t_start;  assign if5.stop = t_stop;  assign if5.sample_valid = t_valid;
  assign if5.sample = t_sample; assign if5.pos = t_pos;
  assign if3.start = t_start;  assign if3.stop = t_stop;  assign if3.sample_valid = t_valid;
  assign if3.sample = t_sample; assign if3.pos = t_pos;

  peak_voltage_tracker #(.WIDTH(8), .POS_W(8), .HYST(0), .CNT_W(10)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  peak_voltage_tracker #(.WIDTH(8), .POS_W(8), .HYST(5), .CNT_W(10)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .bus(if5));
  peak_voltage_tracker #(.WIDTH(8), .POS_W(8), .HYST(0), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3));

  logic       a_gt[3], a_busy[3], a_done[3], a_pv[3];
  logic [7:0] a_mv[3], a_mp[3];
  logic [9:0] a_cnt[3];

  assign a_gt[0] = if0.gt;   assign a_busy[0] = if0.busy; assign a_done[0] = if0.done;
  assign a_pv[0] = if0.peak_valid; assign a_mv[0] = if0.max_val; assign a_mp[0] = if0.max_pos;
  assign a_cnt[0] = if0.sample_cnt;
  assign a_gt[1] = if5.gt;   assign a_busy[1] = if5.busy; assign a_done[1] = if5.done;
  assign a_pv[1] = if5.peak_valid; assign a_mv[1] = if5.max_val; assign a_mp[1] = if5.max_pos;
  assign a_cnt[1] = if5.sample_cnt;
  assign a_gt[2] = if3.gt;   assign a_busy[2] = if3.busy; assign a_done[2] = if3.done;
  assign a_pv[2] = if3.peak_valid; assign a_mv[2] = if3.max_val; assign a_mp[2] = if3.max_pos;
  assign a_cnt[2] = {7'b0, if3.sample_cnt};

  // Reference model: plain integers per instance; phase 0 idle, 1 sweeping, 2 publishing.
  int hyst[3]    = '{0, 5, 0};
  int cnt_max[3] = '{1023, 1023, 7};
  int m_phase;
  int m_max[3], m_pos[3], m_cnt[3], m_gt[3], m_first[3];
  int pm_val[3], pm_pos[3], pm_valid[3];

  int checks   = 0;
  int failures = 0;

  function automatic void m_reset();
    m_phase = 0;
    for (int i = 0; i < 3; i++) begin
      m_max[i] = 0; m_pos[i] = 0; m_cnt[i] = 0; m_gt[i] = 0; m_first[i] = 0;
      pm_val[i] = 0; pm_pos[i] = 0; pm_valid[i] = 0;
    end
  endfunction

  function automatic void m_clear(int i);
    m_max[i] = 0; m_pos[i] = 0; m_cnt[i] = 0; m_first[i] = 1;
  endfunction

  function automatic void m_apply(int i, int val, int ps);
    int  thr;
    bit  take;
    thr = m_max[i] + hyst[i];
`ifdef PEAK_TIE_LAST_EN
    take = (m_first[i] != 0) || (val >= thr);
`else
    take = (m_first[i] != 0) || (val > thr);
`endif
    if (m_cnt[i] < cnt_max[i]) m_cnt[i] = m_cnt[i] + 1;
    if (take) begin
      m_max[i] = val; m_pos[i] = ps; m_first[i] = 0;
    end
    m_gt[i] = take ? 1 : 0;
  endfunction

  function automatic void m_step(bit s, bit p, bit v, int val, int ps);
    case (m_phase)
      0: begin
        for (int i = 0; i < 3; i++) begin
          m_gt[i] = 0;
          if (s) m_clear(i);
        end
        if (s) m_phase = 1;
      end
      1: begin
        if (s) begin
          for (int i = 0; i < 3; i++) m_clear(i);
        end else begin
          if (v) for (int i = 0; i < 3; i++) m_apply(i, val, ps);
          if (p) m_phase = 2;
        end
      end
      default: begin
        for (int i = 0; i < 3; i++) begin
          pm_val[i]   = m_first[i] ? 0 : m_max[i];
          pm_pos[i]   = m_first[i] ? 0 : m_pos[i];
          pm_valid[i] = m_first[i] ? 0 : 1;
        end
        m_phase = 0;
      end
    endcase
  endfunction

  // One clock: drive inputs, advance the model, compare every output 1 ns after the edge.
  task automatic drive_cycle(input bit s, input bit p, input bit v, input int val, input int ps);
    t_start = s; t_stop = p; t_valid = v; t_sample = val[7:0]; t_pos = ps[7:0];
    @(posedge clk);
    #1;
    m_step(s, p, v, val, ps);
    t_start = 1'b0; t_stop = 1'b0; t_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (a_busy[i] !== (m_phase == 1)) begin
        failures++; $display("FAIL busy inst%0d got=%0b exp=%0b t=%0t", i, a_busy[i], m_phase == 1, $time);
      end
      checks++;
      if (a_done[i] !== (m_phase == 2)) begin
        failures++; $display("FAIL done inst%0d got=%0b exp=%0b t=%0t", i, a_done[i], m_phase == 2, $time);
      end
      checks++;
      if (a_gt[i] !== m_gt[i][0]) begin
        failures++; $display("FAIL gt inst%0d got=%0b exp=%0d t=%0t", i, a_gt[i], m_gt[i], $time);
      end
      checks++;
      if (a_cnt[i] !== m_cnt[i][9:0]) begin
        failures++; $display("FAIL sample_cnt inst%0d got=%0d exp=%0d t=%0t", i, a_cnt[i], m_cnt[i], $time);
      end
      checks++;
      if (a_mv[i] !== pm_val[i][7:0] || a_mp[i] !== pm_pos[i][7:0] || a_pv[i] !== pm_valid[i][0]) begin
        failures++;
        $display("FAIL published inst%0d got=(%0d,%0d,%0b) exp=(%0d,%0d,%0d) t=%0t", i,
                 a_mv[i], a_mp[i], a_pv[i], pm_val[i], pm_pos[i], pm_valid[i], $time);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({a_gt[i], a_busy[i], a_done[i], a_pv[i], a_mv[i], a_mp[i], a_cnt[i]} !== '0) begin
        failures++; $display("FAIL reset_state inst%0d got gt=%0b busy=%0b done=%0b pv=%0b mv=%0d mp=%0d cnt=%0d exp all 0",
                             i, a_gt[i], a_busy[i], a_done[i], a_pv[i], a_mv[i], a_mp[i], a_cnt[i]);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_sweep();
    int  vals[4] = '{10, 40, 25, 40};
`ifdef PEAK_TIE_LAST_EN
    bit  exp_gt[4] = '{1, 1, 0, 1};
    int  exp_pos = 3;
`else
    bit  exp_gt[4] = '{1, 1, 0, 0};
    int  exp_pos = 1;
`endif
    drive_cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(0, 0, 1, vals[k], k);
      checks++;
      if (a_gt[0] !== exp_gt[k]) begin
        failures++; $display("FAIL basic_gt[%0d] got=%0b exp=%0b", k, a_gt[0], exp_gt[k]);
      end
    end
    drive_cycle(0, 1, 0, 0, 0);
    checks++;
    if (a_done[0] !== 1'b1) begin
      failures++; $display("FAIL basic_done got=%0b exp=1", a_done[0]);
    end
    drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (a_mv[0] !== 8'd40 || a_mp[0] !== exp_pos[7:0] || a_cnt[0] !== 10'd4 || a_pv[0] !== 1'b1) begin
      failures++; $display("FAIL basic_result got=(%0d,%0d,cnt %0d,pv %0b) exp=(40,%0d,cnt 4,pv 1)",
                           a_mv[0], a_mp[0], a_cnt[0], a_pv[0], exp_pos);
    end
  endtask

  task automatic test_hysteresis();
    int vals[4] = '{20, 24, 25, 26};
`ifdef PEAK_TIE_LAST_EN
    bit exp_gt[4] = '{1, 0, 1, 0};
    int exp_max = 25;
`else
    bit exp_gt[4] = '{1, 0, 0, 1};
    int exp_max = 26;
`endif
    drive_cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(0, 0, 1, vals[k], 10 + k);
      checks++;
      if (a_gt[1] !== exp_gt[k]) begin
        failures++; $display("FAIL hyst_gt[%0d] got=%0b exp=%0b", k, a_gt[1], exp_gt[k]);
      end
    end
    drive_cycle(0, 1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (a_mv[1] !== exp_max[7:0]) begin
      failures++; $display("FAIL hyst_max got=%0d exp=%0d", a_mv[1], exp_max);
    end
  endtask

  task automatic test_stop_with_sample();
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 0, 1, 100, 3);
    drive_cycle(0, 1, 1, 255, 7);
    drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (a_mv[0] !== 8'd255 || a_mp[0] !== 8'd7 || a_cnt[0] !== 10'd2) begin
      failures++; $display("FAIL stop_sample got=(%0d,%0d,cnt %0d) exp=(255,7,cnt 2)", a_mv[0], a_mp[0], a_cnt[0]);
    end
  endtask

  task automatic test_empty_and_restart();
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (a_pv[0] !== 1'b0 || a_mv[0] !== 8'd0 || a_mp[0] !== 8'd0 || a_cnt[0] !== 10'd0) begin
      failures++; $display("FAIL empty_sweep got=(pv %0b,%0d,%0d,cnt %0d) exp=(pv 0,0,0,cnt 0)",
                           a_pv[0], a_mv[0], a_mp[0], a_cnt[0]);
    end
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 0, 1, 200, 1);
    drive_cycle(0, 0, 1, 201, 2);
    drive_cycle(1, 0, 1, 250, 3);
    checks++;
    if (a_cnt[0] !== 10'd0 || a_busy[0] !== 1'b1) begin
      failures++; $display("FAIL restart_clear got=(cnt %0d,busy %0b) exp=(cnt 0,busy 1)", a_cnt[0], a_busy[0]);
    end
    drive_cycle(0, 0, 1, 5, 9);
    drive_cycle(0, 1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (a_mv[0] !== 8'd5 || a_mp[0] !== 8'd9 || a_cnt[0] !== 10'd1) begin
      failures++; $display("FAIL restart_result got=(%0d,%0d,cnt %0d) exp=(5,9,cnt 1)", a_mv[0], a_mp[0], a_cnt[0]);
    end
  endtask

  task automatic test_saturation();
    int vals[10] = '{3, 50, 12, 77, 60, 9, 40, 88, 99, 1};
    drive_cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) drive_cycle(0, 0, 1, vals[k], k);
    drive_cycle(0, 1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (a_cnt[2] !== 10'd7 || a_mv[2] !== 8'd99 || a_mp[2] !== 8'd8) begin
      failures++; $display("FAIL saturate got=(cnt %0d,%0d,%0d) exp=(cnt 7,99,8)", a_cnt[2], a_mv[2], a_mp[2]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 0, 1, 30, 1);
    drive_cycle(0, 0, 1, 60, 2);
    drive_cycle(0, 0, 1, 45, 3);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({a_gt[i], a_busy[i], a_done[i], a_pv[i], a_mv[i], a_mp[i], a_cnt[i]} !== '0) begin
        failures++; $display("FAIL reset_mid inst%0d got gt=%0b busy=%0b done=%0b pv=%0b mv=%0d mp=%0d cnt=%0d exp all 0",
                             i, a_gt[i], a_busy[i], a_done[i], a_pv[i], a_mv[i], a_mp[i], a_cnt[i]);
      end
    end
    #2 rst_n = 1'b1;
    drive_cycle(0, 1, 1, 77, 4);
    drive_cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int sel, val;
    for (int c = 0; c < 1500; c++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0)      val = int'($urandom_range(0, 15));
      else if (sel == 1) val = int'($urandom_range(245, 255));
      else               val = int'($urandom_range(0, 255));
      drive_cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 3) != 0), val, int'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic_sweep();
    test_hysteresis();
    test_stop_with_sample();
    test_empty_and_restart();
    test_saturation();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/peak_voltage_tracker.md
Name: peak_voltage_tracker

Overview:
Parametrised sweep-peak finder, successor to the single-compare ADC-vs-register flag. Consumes a stream of ADC samples tagged with servo position during a sweep and keeps a running maximum with its position. Optional hysteresis suppresses noise-driven updates. At sweep end it publishes the peak value/position to the tracker control FSM with a DONE pulse.

Parameters:
WIDTH, 8, ADC sample width in bits
POS_W, 8, servo position tag width in bits
HYST, 0, minimum margin above the running max required to update (unsigned, < 2^WIDTH)
CNT_W, 10, sample counter width

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  begin new sweep (single-cycle pulse)
STOP  in  1  end current sweep (single-cycle pulse)
SAMPLE_VALID  in  1  SAMPLE/POS valid this cycle
SAMPLE  in  WIDTH  ADC value (pending value)
POS  in  POS_W  servo position of SAMPLE
GT  out  1  registered: last valid sample updated the running max
BUSY  out  1  high in SWEEP
DONE  out  1  one-cycle pulse when results are published
PEAK_VALID  out  1  published result contains at least one sample
MAX_VAL  out  WIDTH  published peak value
MAX_POS  out  POS_W  published peak position
SAMPLE_CNT  out  CNT_W  valid samples accepted in last/current sweep, saturating

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; GT, BUSY, DONE, PEAK_VALID=0; MAX_VAL, MAX_POS, SAMPLE_CNT=0; internal run_max/run_pos/first flag cleared.
- States: IDLE, SWEEP, PUBLISH.
- IDLE: START -> SWEEP next cycle; clears run_max, run_pos, SAMPLE_CNT; sets first=1. SAMPLE_VALID ignored in IDLE; GT held 0.
- SWEEP: BUSY=1. On SAMPLE_VALID: SAMPLE_CNT += 1 (saturates at 2^CNT_W-1, no wrap).
  - first=1: unconditionally capture SAMPLE/POS, GT<=1, first<=0.
  - else update iff SAMPLE > run_max + HYST, computed at WIDTH+1 bits (no overflow; run_max+HYST beyond range means no update). Update -> GT<=1, else GT<=0.
  - GT updates only on valid cycles; holds otherwise. Latency 1 cycle sample->GT/run_max.
- STOP in SWEEP -> PUBLISH. STOP coinciding with SAMPLE_VALID: sample is processed first and included in the result.
- START in SWEEP (with or without STOP): restart; state stays SWEEP, run values and count cleared, first=1; same-cycle sample discarded.
- PUBLISH (one cycle): MAX_VAL<=run_max, MAX_POS<=run_pos, PEAK_VALID<=!first, DONE=1, -> IDLE. Zero samples: MAX_VAL/MAX_POS=0, PEAK_VALID=0. Published outputs hold until next PUBLISH or reset. START in PUBLISH is taken in the following IDLE cycle only if reasserted (ignored here).
- STOP in IDLE/PUBLISH ignored.
- Reset mid-sweep: all outputs to reset values immediately; sweep discarded.

Optional Feature:
PEAK_TIE_LAST_EN
- Defined: update condition becomes SAMPLE >= run_max + HYST (after first sample); equal plateau values move run_pos to latest position (tracks plateau far edge).
- Undefined: strict >; earliest position of a plateau retained.

Test Plan:
- Reset mid-sweep: RST_N low while BUSY after 3 samples -> all outputs 0 same cycle, FSM IDLE, no DONE.
- HYST=0 sweep, samples (val,pos) (10,0),(40,1),(25,2),(40,3),STOP -> DONE, MAX_VAL=40, MAX_POS=1 (macro off) / 3 (macro on), SAMPLE_CNT=4, GT sequence 1,1,0,0 (macro off).
- HYST=5: samples 20,24,25,26,STOP -> MAX_VAL=20 then 26 (26>25); GT 1,0,0,1; MAX_VAL=26.
- STOP with SAMPLE_VALID=1, SAMPLE=255 on same cycle after max 100 -> MAX_VAL=255, SAMPLE_CNT includes it.
- START then STOP with no samples -> DONE, PEAK_VALID=0, MAX_VAL=0, SAMPLE_CNT=0; START mid-sweep -> previous samples dropped, count restarts at 0.
- CNT_W=3: 10 valid samples -> SAMPLE_CNT=7 saturated; max still correct.
